// File: rtl/tlb.sv
// ---------------------------------------------------------------------------
// tlb -- fully associative TLB with two combinational search ports, one
// combinational read port and one synchronous write port. Each entry maps a
// pair of virtual pages (even/odd) that share one vpn2/asid/g tag.
//
// Optional feature macro: TLB_INVALIDATE_EN
//   When defined, an invalidate-all sweep FSM is built: inv_req starts a
//   sweep that clears v0/v1 of one entry per cycle for TLBNUM cycles while
//   inv_busy is high. When undefined, inv_req is ignored and inv_busy is 0.
// ---------------------------------------------------------------------------
module tlb #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    reset,

    // search port 0 (instruction fetch)
    input  logic [18:0]             s0_vpn2,
    input  logic                    s0_odd_page,
    input  logic [7:0]              s0_asid,
    output logic                    s0_found,
    output logic [TLBNUM_WIDTH-1:0] s0_index,
    output logic [19:0]             s0_pfn,
    output logic [2:0]              s0_c,
    output logic                    s0_d,
    output logic                    s0_v,

    // search port 1 (load/store/tlbp)
    input  logic [18:0]             s1_vpn2,
    input  logic                    s1_odd_page,
    input  logic [7:0]              s1_asid,
    output logic                    s1_found,
    output logic [TLBNUM_WIDTH-1:0] s1_index,
    output logic [19:0]             s1_pfn,
    output logic [2:0]              s1_c,
    output logic                    s1_d,
    output logic                    s1_v,

    // probe result for tlbp: MSB set means "not found"
    output logic [TLBNUM_WIDTH:0]   p_result,

    // write port
    input  logic                    we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,

    // read port
    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1,

    // invalidate-all sweep
    input  logic                    inv_req,
    output logic                    inv_busy
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                    found;
        logic [TLBNUM_WIDTH-1:0] index;
        logic [19:0]             pfn;
        logic [2:0]              c;
        logic                    d;
        logic                    v;
    } search_res_t;

    tlb_entry_t entry_q [TLBNUM];
    tlb_entry_t entry_d [TLBNUM];

    // sweep controls seen by the entry update logic
    logic                    sweep_clr;
    logic [TLBNUM_WIDTH-1:0] sweep_idx;

    // Scans from the top index down so the lowest matching entry is the one
    // left in the result. The valid bit deliberately plays no part in the
    // match; a miss leaves every field at zero.
    function automatic search_res_t lookup(
        input tlb_entry_t  tbl [TLBNUM],
        input logic [18:0] vpn2,
        input logic        odd,
        input logic [7:0]  asid
    );
        search_res_t res;
        res = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tbl[i].vpn2 == vpn2 && (tbl[i].g || tbl[i].asid == asid)) begin
                res.found = 1'b1;
                res.index = TLBNUM_WIDTH'(i);
                if (odd) begin
                    res.pfn = tbl[i].pfn1;
                    res.c   = tbl[i].c1;
                    res.d   = tbl[i].d1;
                    res.v   = tbl[i].v1;
                end else begin
                    res.pfn = tbl[i].pfn0;
                    res.c   = tbl[i].c0;
                    res.d   = tbl[i].d0;
                    res.v   = tbl[i].v0;
                end
            end
        end
        return res;
    endfunction

`ifdef TLB_INVALIDATE_EN

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    sweep_state_t            state_q, state_d;
    logic [TLBNUM_WIDTH-1:0] cnt_q,   cnt_d;

    // Sweep state and entry counter; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: flops take non-blocking assignments so every register
            // samples the pre-edge value of every other register.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start on inv_req, walk every entry once, then return.
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a
        // variable unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (inv_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == TLBNUM_WIDTH'(TLBNUM - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TLBNUM_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: busy and the per-cycle clear strobe follow the SWEEP state.
    always_comb begin
        inv_busy  = (state_q == SWEEP);
        sweep_clr = (state_q == SWEEP);
        sweep_idx = cnt_q;
    end

`else

    logic unused_inv_req;

    assign unused_inv_req = inv_req;
    assign inv_busy       = 1'b0;
    assign sweep_clr      = 1'b0;
    assign sweep_idx      = '0;

`endif

    // Entry next-state: sweep clears the valid bits first, so a write to the
    // same entry in the same cycle overrides the clear.
    always_comb begin
        entry_d = entry_q;
        if (sweep_clr) begin
            entry_d[sweep_idx].v0 = 1'b0;
            entry_d[sweep_idx].v1 = 1'b0;
        end
        if (we) begin
            entry_d[w_index] = {w_vpn2, w_asid, w_g,
                                w_pfn0, w_c0, w_d0, w_v0,
                                w_pfn1, w_c1, w_d1, w_v1};
        end
    end

    // Entry storage: the whole array clears asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this array sits in flops, not a RAM macro, so it can
            // and must be cleared by reset; a RAM could not be.
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    search_res_t s0_res, s1_res;

    // Both search ports look at the current (pre-write) array contents.
    always_comb begin
        s0_res = lookup(entry_q, s0_vpn2, s0_odd_page, s0_asid);
        s1_res = lookup(entry_q, s1_vpn2, s1_odd_page, s1_asid);
    end

    assign s0_found = s0_res.found;
    assign s0_index = s0_res.index;
    assign s0_pfn   = s0_res.pfn;
    assign s0_c     = s0_res.c;
    assign s0_d     = s0_res.d;
    assign s0_v     = s0_res.v;

    assign s1_found = s1_res.found;
    assign s1_index = s1_res.index;
    assign s1_pfn   = s1_res.pfn;
    assign s1_c     = s1_res.c;
    assign s1_d     = s1_res.d;
    assign s1_v     = s1_res.v;

    assign p_result = {~s1_res.found, s1_res.index};

    assign r_vpn2 = entry_q[r_index].vpn2;
    assign r_asid = entry_q[r_index].asid;
    assign r_g    = entry_q[r_index].g;
    assign r_pfn0 = entry_q[r_index].pfn0;
    assign r_c0   = entry_q[r_index].c0;
    assign r_d0   = entry_q[r_index].d0;
    assign r_v0   = entry_q[r_index].v0;
    assign r_pfn1 = entry_q[r_index].pfn1;
    assign r_c1   = entry_q[r_index].c1;
    assign r_d1   = entry_q[r_index].d1;
    assign r_v1   = entry_q[r_index].v1;

endmodule
